// File: rtl/wallet_txn_feeder.sv
// wallet_txn_feeder: buffers per-wallet records and streams them to the tracer, framing each wallet and capturing its score.
// Optional macro FEEDER_TS_CHECK_EN enables the sticky in-wallet timestamp-order check on ts_err.
module wallet_txn_feeder #(
  parameter int DEPTH = 16,
  parameter int MAX_TXN = 64,
  parameter int SCORE_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_last,
  input  logic [9:0]  s_time_stamp,
  input  logic        s_in,
  input  logic [1:0]  s_method,
  input  logic [29:0] s_value,
  output logic [9:0]  time_stamp,
  output logic        in,
  output logic [1:0]  method_field,
  output logic [29:0] value,
  output logic        txn_valid,
  output logic        new_wallet,
  input  logic [6:0]  confidence_score,
  output logic [6:0]  score_out,
  output logic        score_valid,
  output logic        truncated,
  output logic [6:0]  txn_count,
  output logic [15:0] wallet_count,
  output logic        ts_err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, STREAM, CLOSE, WAIT} state_t;
  state_t state, state_nx;
  logic [43:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [43:0] head;
  logic [6:0] cnt_nx;
  logic [3:0] lat_cnt;
  logic empty, full, push, pop, close, last_cycle, trunc_flag;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign s_ready = !full;
  assign push = s_valid && s_ready;
  assign head = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= {s_last, s_time_stamp, s_in, s_method, s_value};

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = empty ? IDLE : STREAM;
      STREAM:  state_nx = close ? CLOSE : STREAM;
      CLOSE:   state_nx = WAIT;
      WAIT:    state_nx = !last_cycle ? WAIT : empty ? IDLE : STREAM;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cnt_nx = (txn_count == 7'd127) ? txn_count : txn_count + 7'd1;
    pop = (state == STREAM) && !empty;
    close = pop && (head[43] || cnt_nx == 7'(MAX_TXN));
    last_cycle = (state == WAIT) && (lat_cnt == 4'(SCORE_LAT - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      lat_cnt <= '0;
      trunc_flag <= 1'b0;
      {time_stamp, in, method_field, value} <= '0;
      txn_valid <= 1'b0;
      new_wallet <= 1'b0;
      score_out <= '0;
      score_valid <= 1'b0;
      truncated <= 1'b0;
      txn_count <= '0;
      wallet_count <= '0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      txn_valid <= pop;
      new_wallet <= state == CLOSE;
      score_valid <= last_cycle;
      truncated <= last_cycle && trunc_flag;
      lat_cnt <= (state == WAIT) ? lat_cnt + 4'd1 : 4'd0;
      if (pop) begin
        {time_stamp, in, method_field, value} <= head[42:0];
        txn_count <= cnt_nx;
      end else if (state == IDLE) begin
        {time_stamp, in, method_field, value} <= '0;
      end
      if (close) trunc_flag <= !head[43];
      if (last_cycle) begin
        score_out <= confidence_score;
        wallet_count <= wallet_count + 16'd1;
        txn_count <= '0;
      end
    end
  end

`ifdef FEEDER_TS_CHECK_EN
  // The output time_stamp register holds the previous pop of this wallet; the first pop is skipped.
  always_ff @(posedge clk)
    if (!rst_n) ts_err <= 1'b0;
    else if (pop && txn_count != 7'd0 && head[42:33] < time_stamp) ts_err <= 1'b1;
`else
  assign ts_err = 1'b0;
`endif
endmodule

// File: tb/tb_wallet_txn_feeder.sv
// tb_wallet_txn_feeder: scoreboard bench for wallet_txn_feeder (DEPTH=4, MAX_TXN=4, SCORE_LAT=3).
module tb_wallet_txn_feeder;
  localparam int DEPTH = 4;
  localparam int MAX_TXN = 4;
  localparam int SCORE_LAT = 3;
  logic clk = 0, rst_n = 0;
  logic s_valid = 0, s_ready, s_last = 0, s_in = 0;
  logic [9:0] s_time_stamp = '0;
  logic [1:0] s_method = '0;
  logic [29:0] s_value = '0;
  logic [9:0] time_stamp;
  logic in, txn_valid, new_wallet, score_valid, truncated, ts_err;
  logic [1:0] method_field;
  logic [29:0] value;
  logic [6:0] confidence_score = '0, score_out, txn_count;
  logic [15:0] wallet_count;

  wallet_txn_feeder #(.DEPTH(DEPTH), .MAX_TXN(MAX_TXN), .SCORE_LAT(SCORE_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .s_time_stamp(s_time_stamp), .s_in(s_in), .s_method(s_method), .s_value(s_value),
    .time_stamp(time_stamp), .in(in), .method_field(method_field), .value(value),
    .txn_valid(txn_valid), .new_wallet(new_wallet), .confidence_score(confidence_score),
    .score_out(score_out), .score_valid(score_valid), .truncated(truncated),
    .txn_count(txn_count), .wallet_count(wallet_count), .ts_err(ts_err)
  );

  always #5 clk = ~clk;

`ifdef FEEDER_TS_CHECK_EN
  localparam logic TS_EXP = 1'b1;
`else
  localparam logic TS_EXP = 1'b0;
`endif

  logic [43:0] q[$];
  int checks = 0, failures = 0;
  int mcnt = 0, mwal = 0, sv_cd = 0, trunc_seen = 0, txn_seen = 0;
  logic nw_pend = 0, exp_tr = 0, exp_sv = 0, saw_full = 0;
  logic [6:0] cs_last = '0;
  logic [43:0] e;

  always @(posedge clk)
    if (rst_n && s_valid && s_ready) q.push_back({s_last, s_time_stamp, s_in, s_method, s_value});

  // Reference model of wallet framing, checked every cycle against the DUT.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      mcnt = 0; mwal = 0; sv_cd = 0; nw_pend = 0; exp_tr = 0;
    end else begin
      exp_sv = 0;
      if (sv_cd > 0) begin sv_cd--; exp_sv = (sv_cd == 0); end
      checks++;
      if (new_wallet !== nw_pend) begin failures++; $display("FAIL new_wallet got=%0b exp=%0b t=%0t", new_wallet, nw_pend, $time); end
      if (new_wallet) sv_cd = SCORE_LAT;
      nw_pend = 0;
      checks++;
      if (score_valid !== exp_sv) begin failures++; $display("FAIL score_valid got=%0b exp=%0b t=%0t", score_valid, exp_sv, $time); end
      checks++;
      if (truncated !== (exp_sv & exp_tr)) begin failures++; $display("FAIL truncated got=%0b exp=%0b t=%0t", truncated, exp_sv & exp_tr, $time); end
      if (exp_sv) begin
        checks++;
        if (score_out !== cs_last) begin failures++; $display("FAIL score_out got=%0d exp=%0d", score_out, cs_last); end
        mwal++; mcnt = 0;
        if (exp_tr) trunc_seen++;
      end
      checks++;
      if (txn_valid && new_wallet) begin failures++; $display("FAIL txn_valid_with_new_wallet t=%0t", $time); end
      if (txn_valid) begin
        txn_seen++;
        checks++;
        if (q.size() == 0) begin failures++; $display("FAIL txn_unexpected ts=%0d t=%0t", time_stamp, $time); end
        else begin
          e = q.pop_front();
          if ({time_stamp, in, method_field, value} !== e[42:0]) begin
            failures++; $display("FAIL txn_data got=%h exp=%h", {time_stamp, in, method_field, value}, e[42:0]);
          end
          mcnt++;
          if (e[43] || mcnt == MAX_TXN) begin nw_pend = 1; exp_tr = !e[43]; end
        end
      end
      checks++;
      if (txn_count !== 7'(mcnt)) begin failures++; $display("FAIL txn_count got=%0d exp=%0d t=%0t", txn_count, mcnt, $time); end
      checks++;
      if (wallet_count !== 16'(mwal)) begin failures++; $display("FAIL wallet_count got=%0d exp=%0d t=%0t", wallet_count, mwal, $time); end
    end
    cs_last = confidence_score;
  end

  task automatic send(input logic l, input logic [9:0] ts);
    int n = 0;
    s_valid = 1; s_last = l; s_time_stamp = ts; s_in = ts[0]; s_method = ts[2:1]; s_value = 30'($urandom);
    while (!s_ready && n < 200) begin saw_full = 1; @(posedge clk); #1; n++; end
    checks++;
    if (n >= 200) begin failures++; $display("FAIL send_timeout ts=%0d", ts); end
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    s_valid = 0;
    while ((q.size() != 0 || nw_pend || sv_cd != 0) && n < 500) begin @(posedge clk); #1; n++; end
    checks++;
    if (n >= 500) begin failures++; $display("FAIL drain_timeout left=%0d", q.size()); end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if ({txn_valid, new_wallet, score_valid, truncated, txn_count, wallet_count, score_out,
         time_stamp, in, method_field, value, ts_err} !== '0) begin
      failures++; $display("FAIL %s outputs not zero tv=%0b nw=%0b sv=%0b tc=%0d wc=%0d", tag, txn_valid, new_wallet, score_valid, txn_count, wallet_count);
    end
    checks++;
    if (s_ready !== 1'b1) begin failures++; $display("FAIL %s s_ready got=%0b exp=1", tag, s_ready); end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk); #1;
    check_zero("reset_hold");
    rst_n = 1;
    @(posedge clk); #1;
    check_zero("reset_release");
  endtask

  task automatic test_basic();
    int t0 = txn_seen;
    confidence_score = 7'd11;
    send(0, 10'd5); send(0, 10'd6); send(1, 10'd7);
    wait_drain();
    checks++;
    if (txn_seen - t0 != 3) begin failures++; $display("FAIL basic_txn_cycles got=%0d exp=3", txn_seen - t0); end
    checks++;
    if (wallet_count !== 16'd1) begin failures++; $display("FAIL basic_wallet_count got=%0d exp=1", wallet_count); end
    checks++;
    if (score_out !== 7'd11) begin failures++; $display("FAIL basic_score got=%0d exp=11", score_out); end
  endtask

  task automatic test_forced_close();
    logic [15:0] wc0 = wallet_count;
    int tr0 = trunc_seen;
    for (int i = 0; i < 6; i++) send(i == 5, 10'(20 + i));
    wait_drain();
    checks++;
    if (wallet_count !== wc0 + 16'd2) begin failures++; $display("FAIL forced_wallets got=%0d exp=%0d", wallet_count, wc0 + 16'd2); end
    checks++;
    if (trunc_seen - tr0 != 1) begin failures++; $display("FAIL forced_truncated got=%0d exp=1", trunc_seen - tr0); end
  endtask

  task automatic test_score_hold();
    int n = 0;
    confidence_score = 7'd42;
    send(1, 10'd30);
    wait_drain();
    checks++;
    if (score_out !== 7'd42) begin failures++; $display("FAIL score_capture got=%0d exp=42", score_out); end
    confidence_score = 7'd9;
    send(0, 10'd31); send(1, 10'd32);
    s_valid = 0;
    while (!new_wallet && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (n >= 100 || score_out !== 7'd42) begin failures++; $display("FAIL score_held got=%0d exp=42 waited=%0d", score_out, n); end
    wait_drain();
    checks++;
    if (score_out !== 7'd9) begin failures++; $display("FAIL score_next got=%0d exp=9", score_out); end
  endtask

  task automatic test_back_to_back();
    saw_full = 0;
    for (int i = 0; i < 16; i++) send(i == 6 || i == 13 || i == 15, 10'(100 + i));
    wait_drain();
    checks++;
    if (saw_full !== 1'b1) begin failures++; $display("FAIL fifo_full_backpressure got=%0b exp=1", saw_full); end
  endtask

  task automatic test_reset_mid();
    int t0;
    send(0, 10'd50); send(0, 10'd51); send(0, 10'd52);
    s_valid = 0;
    rst_n = 0;
    @(posedge clk); #1;
    check_zero("reset_mid");
    rst_n = 1;
    t0 = txn_seen;
    repeat (8) @(posedge clk); #1;
    checks++;
    if (txn_seen != t0) begin failures++; $display("FAIL stale_records got=%0d exp=0", txn_seen - t0); end
    confidence_score = 7'd3;
    send(0, 10'd60); send(1, 10'd61);
    wait_drain();
    checks++;
    if (wallet_count !== 16'd1) begin failures++; $display("FAIL post_reset_wallets got=%0d exp=1", wallet_count); end
  endtask

  task automatic test_ts_check();
    checks++;
    if (ts_err !== 1'b0) begin failures++; $display("FAIL ts_err_clean got=%0b exp=0", ts_err); end
    send(0, 10'd10); send(1, 10'd9);
    wait_drain();
    checks++;
    if (ts_err !== TS_EXP) begin failures++; $display("FAIL ts_err_set got=%0b exp=%0b", ts_err, TS_EXP); end
    send(1, 10'd1);
    wait_drain();
    checks++;
    if (ts_err !== TS_EXP) begin failures++; $display("FAIL ts_err_sticky got=%0b exp=%0b", ts_err, TS_EXP); end
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    checks++;
    if (ts_err !== 1'b0) begin failures++; $display("FAIL ts_err_reset got=%0b exp=0", ts_err); end
    send(1, 10'd10); send(1, 10'd3);
    wait_drain();
    checks++;
    if (ts_err !== 1'b0) begin failures++; $display("FAIL ts_err_cross_wallet got=%0b exp=0", ts_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_forced_close();
    test_score_hold();
    test_back_to_back();
    test_reset_mid();
    test_ts_check();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
